// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared byte-serial memory adapter to fetch, load or store drain.
// Define MEM_ARB_FAIRNESS_EN to enable the fetch-starvation counter (limit STARVE_LIMIT).
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_ins,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic        st_done,
  output logic        try_start_insfetch_task,
  output logic [31:0] insfetch_addr,
  input  logic        insfetch_task_done,
  input  logic [31:0] insfetch_ins_full,
  output logic        have_mem_access_task,
  output logic [31:0] mem_access_addr,
  output logic        mem_access_rw,
  output logic [1:0]  mem_access_size,
  output logic [31:0] mem_access_data,
  input  logic        mem_access_task_done,
  input  logic [31:0] mem_access_data_out
);

  if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be within 1..15");
  end

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyLd, StBusySt} state_e;

  state_e      r_state;
  logic        r_if_task;
  logic        r_mem_task;
  logic        r_mem_rw;
  logic [31:0] r_if_addr;
  logic [31:0] r_mem_addr;
  logic [1:0]  r_mem_size;
  logic [31:0] r_mem_data;

  logic w_live;
  logic w_if_starved;
  logic w_grant_if;
  logic w_grant_ld;
  logic w_grant_st;

  // The adapter only moves up to a word; size 2'b11 is treated as a word access.
  function automatic logic [1:0] clamp_size(input logic [1:0] size);
    return (size == 2'b11) ? 2'b10 : size;
  endfunction

  always_comb begin
    w_grant_if = 1'b0;
    w_grant_ld = 1'b0;
    w_grant_st = 1'b0;
    if (if_req && (w_if_starved || !(st_req || ld_req))) begin
      w_grant_if = 1'b1;
    end else if (st_req) begin
      w_grant_st = 1'b1;
    end else if (ld_req) begin
      w_grant_ld = 1'b1;
    end
  end

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;

  assign w_if_starved = (r_starve_cnt == StarveMax);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_starve_cnt <= '0;
    end else if (rdy_in) begin
      if (flush_pipline) begin
        r_starve_cnt <= '0;
      end else if (r_state == StIdle) begin
        if (!if_req || w_grant_if) begin
          r_starve_cnt <= '0;
        end else if ((w_grant_st || w_grant_ld) && (r_starve_cnt != StarveMax)) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end
    end
  end
`else
  assign w_if_starved = 1'b0;
`endif

  // A flushed store simply returns to idle; st_req is still held, so it is re-granted.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= StIdle;
      r_if_task  <= 1'b0;
      r_mem_task <= 1'b0;
      r_mem_rw   <= 1'b0;
      r_if_addr  <= '0;
      r_mem_addr <= '0;
      r_mem_size <= '0;
      r_mem_data <= '0;
    end else if (rdy_in) begin
      if (flush_pipline) begin
        r_state    <= StIdle;
        r_if_task  <= 1'b0;
        r_mem_task <= 1'b0;
        r_mem_rw   <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_grant_st) begin
              r_state    <= StBusySt;
              r_mem_task <= 1'b1;
              r_mem_rw   <= 1'b1;
              r_mem_addr <= st_addr;
              r_mem_size <= clamp_size(st_size);
              r_mem_data <= st_data;
            end else if (w_grant_ld) begin
              r_state    <= StBusyLd;
              r_mem_task <= 1'b1;
              r_mem_rw   <= 1'b0;
              r_mem_addr <= ld_addr;
              r_mem_size <= clamp_size(ld_size);
              r_mem_data <= '0;
            end else if (w_grant_if) begin
              r_state   <= StBusyIf;
              r_if_task <= 1'b1;
              r_if_addr <= if_addr;
            end
          end
          StBusyIf: begin
            if (insfetch_task_done) begin
              r_state   <= StIdle;
              r_if_task <= 1'b0;
            end
          end
          StBusyLd, StBusySt: begin
            if (mem_access_task_done) begin
              r_state    <= StIdle;
              r_mem_task <= 1'b0;
              r_mem_rw   <= 1'b0;
            end
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  assign try_start_insfetch_task = r_if_task;
  assign insfetch_addr           = r_if_addr;
  assign have_mem_access_task    = r_mem_task;
  assign mem_access_addr         = r_mem_addr;
  assign mem_access_rw           = r_mem_rw;
  assign mem_access_size         = r_mem_size;
  assign mem_access_data         = r_mem_data;

  // Adapter data is only valid in its done cycle, so completions pass straight through.
  assign w_live  = rdy_in & ~flush_pipline;
  assign if_done = (r_state == StBusyIf) & insfetch_task_done & w_live;
  assign ld_done = (r_state == StBusyLd) & mem_access_task_done & w_live;
  assign st_done = (r_state == StBusySt) & mem_access_task_done & w_live;
  assign if_ins  = insfetch_ins_full;
  assign ld_data = mem_access_data_out;

endmodule
